// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer: collects an 8-sample vector and drives eight 8-tap MAC passes, one per coefficient
//   clk, rst               : clock, asynchronous active-high reset
//   din/din_valid/din_ready: sample input handshake (accepted only in IDLE/LOAD)
//   mac_clr/mac_ena/mac_x  : MAC unit control and operand, coef_addr = {k, n}
//   mac_result             : MAC accumulator output, captured after MAC_LAT cycles
//   dout/dout_idx/dout_valid/dout_ready: coefficient output handshake
//   busy                   : high whenever not IDLE
module dct_mac_sequencer #(
    parameter int DW      = 8,
    parameter int RW      = 12,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          mac_clr,
    output logic          mac_ena,
    output logic [DW-1:0] mac_x,
    output logic [5:0]    coef_addr,
    input  logic [RW-1:0] mac_result,
    output logic [RW-1:0] dout,
    output logic [2:0]    dout_idx,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, LOAD, MAC, WAIT, OUT} state_t;
    state_t state, state_nxt;
    logic [2:0] n, k;
    logic [1:0] w;
    logic [DW-1:0] smp [8];
    logic accept, last_wait;
    assign accept    = din_valid & din_ready;
    assign last_wait = (w == 2'(MAC_LAT - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? LOAD : IDLE;
            LOAD:    state_nxt = (accept && n == 3'd7) ? MAC : LOAD;
            MAC:     state_nxt = (n == 3'd7) ? WAIT : MAC;
            WAIT:    state_nxt = last_wait ? OUT : WAIT;
            OUT:     state_nxt = dout_ready ? ((k == 3'd7) ? IDLE : MAC) : OUT;
            default: state_nxt = IDLE;
        endcase
    end
    // n doubles as the load index and the tap index; both wrap to 0 on the way into MAC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n        <= '0;
            k        <= '0;
            w        <= '0;
            dout     <= '0;
            dout_idx <= '0;
            for (int i = 0; i < 8; i++) smp[i] <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    smp[0] <= din;
                    n      <= 3'd1;
                    k      <= '0;
                end
                LOAD: if (accept) begin
                    smp[n] <= din;
                    n      <= n + 3'd1;
                end
                MAC: begin
                    n <= n + 3'd1;
                    w <= '0;
                end
                WAIT: begin
                    w <= w + 2'd1;
                    if (last_wait) begin
                        dout     <= mac_result;
                        dout_idx <= k;
                    end
                end
                OUT: if (dout_ready) k <= k + 3'd1;
                default: ;
            endcase
        end
    end
    // outputs decode registered state only; din_ready is also masked by rst so it drops immediately
    assign busy       = (state != IDLE);
    assign din_ready  = ~rst & (state == IDLE || state == LOAD);
    assign mac_ena    = (state == MAC);
    assign mac_clr    = mac_ena & (n == 3'd0);
    assign mac_x      = mac_ena ? smp[n] : '0;
    assign coef_addr  = mac_ena ? {k, n} : 6'd0;
    assign dout_valid = (state == OUT);
endmodule

// File: tb/tb_dct_mac_sequencer.sv
// tb_dct_mac_sequencer: directed bench driving three sequencers (MAC_LAT 1, 2, 4) against behavioural MAC models
module tb_dct_mac_sequencer;
    localparam int DW = 8;
    localparam int RW = 12;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic din_valid = 1'b0;
    logic dout_ready = 1'b0;
    logic din_ready [3];
    logic mac_clr [3];
    logic mac_ena [3];
    logic [DW-1:0] mac_x [3];
    logic [5:0] coef_addr [3];
    logic [RW-1:0] mac_result [3];
    logic [RW-1:0] dout [3];
    logic [2:0] dout_idx [3];
    logic dout_valid [3];
    logic busy [3];
    int cyc = 0;
    int coef_mode = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int got_n [3];
    logic [RW-1:0] got_v [3][128];
    logic [2:0] got_i [3][128];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // lane 1 (MAC_LAT=2) is the primary DUT; lanes 0 and 2 share its inputs
    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        int acc;
        int pipe [4];
        dct_mac_sequencer #(.DW(DW), .RW(RW), .MAC_LAT(L)) dut (
            .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[g]),
            .mac_clr(mac_clr[g]), .mac_ena(mac_ena[g]), .mac_x(mac_x[g]), .coef_addr(coef_addr[g]),
            .mac_result(mac_result[g]), .dout(dout[g]), .dout_idx(dout_idx[g]),
            .dout_valid(dout_valid[g]), .dout_ready(dout_ready), .busy(busy[g])
        );
        // ROM: coef = 1 (mode 0) or k+1 (mode 1); sum is valid L cycles after the last enable
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                acc <= 0;
                for (int i = 0; i < 4; i++) pipe[i] <= 0;
            end else begin
                if (mac_ena[g])
                    acc <= (mac_clr[g] ? 0 : acc) + $signed(mac_x[g]) * ((coef_mode != 0) ? int'(coef_addr[g][5:3]) + 1 : 1);
                pipe[0] <= acc;
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign mac_result[g] = RW'((L == 1) ? acc : pipe[(L > 1) ? L - 2 : 0]);
    end

    always @(negedge clk)
        for (int j = 0; j < 3; j++)
            if (dout_valid[j] && dout_ready && got_n[j] < 128) begin
                got_v[j][got_n[j]] <= dout[j];
                got_i[j][got_n[j]] <= dout_idx[j];
                got_n[j] <= got_n[j] + 1;
            end

    function automatic logic [33:0] outs(input int j);
        return {din_ready[j], mac_clr[j], mac_ena[j], mac_x[j], coef_addr[j], dout[j], dout_idx[j], dout_valid[j], busy[j]};
    endfunction

    task automatic run_vec(input logic [DW-1:0] s [8], input int gap, input int stall_k, input bit chk_total, input int cm, input string nm);
        int base [3];
        int first_acc, last_acc, e, held, last_hs, n7_cyc, rise_cyc, hs_cnt, sum, expv;
        bit arm, pv;
        logic [RW-1:0] hold_d;
        logic [2:0] hold_i;
        coef_mode = cm;
        for (int j = 0; j < 3; j++) base[j] = got_n[j];
        first_acc = 0;
        last_acc = 0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < ((i > 0) ? gap : 0); g++) begin
                din_valid = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (mac_ena[1] !== 1'b0 || busy[1] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s gap_stall: mac_ena=%b busy=%b, required 0/1", nm, mac_ena[1], busy[1]);
                end
                @(posedge clk); #2;
            end
            din = s[i];
            din_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (din_ready[1] !== 1'b1 || mac_ena[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL %s load_%0d: din_ready=%b mac_ena=%b, required 1/0", nm, i, din_ready[1], mac_ena[1]);
            end
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk); #2;
        end
        din_valid = 1'b0;
        din = '0;
        e = 0; held = 0; last_hs = -1; n7_cyc = -100; rise_cyc = -1; hs_cnt = 0; arm = 0; pv = 0;
        hold_d = '0; hold_i = '0;
        dout_ready = 1'b1;
        for (int t = 0; t < 400 && hs_cnt < 8; t++) begin
            @(negedge clk);
            if (mac_ena[1]) begin
                n_cmp++;
                if ({mac_clr[1], coef_addr[1], mac_x[1]} !== {(e % 8 == 0), 6'(e), s[e % 8]}) begin
                    n_bad++;
                    $display("FAIL %s mac_%0d: clr=%b addr=%0d x=%h, required %b/%0d/%h", nm, e,
                             mac_clr[1], coef_addr[1], mac_x[1], (e % 8 == 0), e, s[e % 8]);
                end
                if (e % 8 == 0) begin
                    n_cmp++;
                    if (cyc !== ((e == 0) ? last_acc + 1 : last_hs + 1)) begin
                        n_bad++;
                        $display("FAIL %s pass_start_k%0d: cycle %0d, required %0d", nm, e / 8, cyc, (e == 0) ? last_acc + 1 : last_hs + 1);
                    end
                end
                if (e % 8 == 7) n7_cyc = cyc;
                if (e / 8 == stall_k) arm = 1;
                e++;
            end else begin
                n_cmp++;
                if ({mac_clr[1], coef_addr[1], mac_x[1]} !== 15'd0) begin
                    n_bad++;
                    $display("FAIL %s idle_mac_outputs: clr=%b addr=%0d x=%h, required 0", nm, mac_clr[1], coef_addr[1], mac_x[1]);
                end
            end
            if (dout_valid[1] && !pv) begin
                n_cmp++;
                if (cyc !== n7_cyc + 3) begin
                    n_bad++;
                    $display("FAIL %s valid_rise: cycle %0d, required %0d", nm, cyc, n7_cyc + 3);
                end
                if (rise_cyc < 0) rise_cyc = cyc;
            end
            if (dout_valid[1] && !dout_ready) begin
                n_cmp++;
                if (held == 0 && dout_idx[1] !== 3'(stall_k)) begin
                    n_bad++;
                    $display("FAIL %s stall_idx: %0d, required %0d", nm, dout_idx[1], stall_k);
                end else if (held > 0 && {dout[1], dout_idx[1], mac_ena[1]} !== {hold_d, hold_i, 1'b0}) begin
                    n_bad++;
                    $display("FAIL %s stall_hold: dout=%h idx=%0d ena=%b, required %h/%0d/0", nm, dout[1], dout_idx[1], mac_ena[1], hold_d, hold_i);
                end
                hold_d = dout[1];
                hold_i = dout_idx[1];
                held++;
            end
            if (dout_valid[1] && dout_ready) begin
                last_hs = cyc;
                hs_cnt++;
            end
            pv = dout_valid[1];
            @(posedge clk); #2;
            dout_ready = !(arm && held < 5);
        end
        n_cmp++;
        if (hs_cnt !== 8) begin
            n_bad++;
            $display("FAIL %s timeout: %0d handshakes, required 8", nm, hs_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (din_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s back_to_idle: din_ready=%b busy=%b, required 1/0", nm, din_ready[1], busy[1]);
        end
        n_cmp++;
        if (rise_cyc !== last_acc + 11) begin
            n_bad++;
            $display("FAIL %s first_valid: cycle %0d, required %0d", nm, rise_cyc, last_acc + 11);
        end
        if (stall_k >= 0) begin
            n_cmp++;
            if (held !== 5) begin
                n_bad++;
                $display("FAIL %s stall_len: %0d, required 5", nm, held);
            end
        end
        if (chk_total) begin
            n_cmp++;
            if (last_hs - first_acc + 1 !== 96) begin
                n_bad++;
                $display("FAIL %s total_cycles: %0d, required 96", nm, last_hs - first_acc + 1);
            end
        end
        for (int t = 0; t < 300 && (got_n[0] < base[0] + 8 || got_n[1] < base[1] + 8 || got_n[2] < base[2] + 8); t++)
            @(negedge clk);
        @(posedge clk); #2;
        sum = 0;
        for (int i = 0; i < 8; i++) sum = sum + int'($signed(s[i]));
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 8; k++) begin
                expv = sum * ((cm != 0) ? k + 1 : 1);
                n_cmp++;
                if ({got_v[j][base[j] + k], got_i[j][base[j] + k]} !== {RW'(expv), 3'(k)}) begin
                    n_bad++;
                    $display("FAIL %s result_lane%0d_k%0d: %h idx %0d, required %h idx %0d", nm, j, k,
                             got_v[j][base[j] + k], got_i[j][base[j] + k], RW'(expv), k);
                end
            end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (outs(j) !== 34'd0) begin
                n_bad++;
                $display("FAIL reset_outputs lane%0d: %h, required 0", j, outs(j));
            end
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (din_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: din_ready=%b busy=%b, required 1/0", din_ready[1], busy[1]);
        end
        @(posedge clk); #2;
        din = 8'h55;
        din_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
        end
        din_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL partial_load_busy: %b, required 1", busy[1]);
        end
        #3 rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (outs(j) !== 34'd0) begin
                n_bad++;
                $display("FAIL async_reset lane%0d: %h, required 0", j, outs(j));
            end
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (din_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL async_release: din_ready=%b busy=%b, required 1/0", din_ready[1], busy[1]);
        end
        @(posedge clk); #2;
    endtask

    // samples 1..8, coef 1: every coefficient is 36
    task automatic test_basic();
        logic [DW-1:0] v [8];
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        run_vec(v, 0, -1, 1, 0, "basic");
    endtask

    // sum = 107, coef k+1: 107*(k+1)
    task automatic test_input_gaps();
        logic [DW-1:0] v [8];
        v = '{8'hFD, 8'h05, 8'h64, 8'h80, 8'h7F, 8'h00, 8'h07, 8'hFF};
        run_vec(v, 2, -1, 0, 1, "gaps");
    endtask

    // sum = -1, coef k+1: -(k+1) as 12-bit two's complement
    task automatic test_backpressure();
        logic [DW-1:0] v [8];
        v = '{8'h80, 8'h7F, 8'h01, 8'hFF, 8'h10, 8'hF0, 8'h22, 8'hDE};
        run_vec(v, 0, 3, 0, 1, "backpressure");
    endtask

    // sum = 1016, coef k+1: wraps past 12 bits from k=4 (e.g. 5080 -> 984)
    task automatic test_back_to_back();
        logic [DW-1:0] v [8];
        v = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        run_vec(v, 0, -1, 1, 1, "wrap");
    endtask

    task automatic test_reset_mid_mac();
        logic [DW-1:0] v [8];
        bit found;
        coef_mode = 1;
        v = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        for (int i = 0; i < 8; i++) begin
            din = v[i];
            din_valid = 1'b1;
            @(posedge clk); #2;
        end
        din_valid = 1'b0;
        dout_ready = 1'b1;
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (mac_ena[1] && coef_addr[1] == 6'd20) found = 1;
            else begin
                @(posedge clk); #2;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL mid_reset_reach: k2 n4 not reached, required reached");
        end
        #3 rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (outs(j) !== 34'd0) begin
                n_bad++;
                $display("FAIL mid_reset_outputs lane%0d: %h, required 0", j, outs(j));
            end
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (din_ready[j] !== 1'b1 || busy[j] !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset_release lane%0d: din_ready=%b busy=%b, required 1/0", j, din_ready[j], busy[j]);
            end
        end
        @(posedge clk); #2;
        v = '{8'hF8, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        run_vec(v, 0, -1, 1, 1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_input_gaps();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
